// File: rtl/adat_stream_tx.sv
// ADAT transmitter: stages 8x24-bit samples, serialises 256-bit frames with NRZI line coding.
// Latency: samples accepted during frame N go out in frame N+1; bit_en paces one line bit per strobe.
// Backpressure: s_ready drops once 8 samples are staged and during the frame-load cycle.
module adat_stream_tx #(
    parameter bit UNDERRUN_HOLD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_en,
    input  logic [23:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  user_bits,
    output logic        adat_bitstream,
    output logic        frame_start,
    output logic        underrun,
    output logic [2:0]  chan_idx
);

    logic [23:0]  staging [8];
    logic [23:0]  tx_smp  [8];
    logic [3:0]   chan_cnt;
    logic [7:0]   bit_idx;
    logic [3:0]   user_q;
    logic [255:0] frame_msb;
    logic         load;
    logic         accept;

    function automatic logic [29:0] chan_field(input logic [23:0] s);
        chan_field = {1'b1, s[23:20], 1'b1, s[19:16], 1'b1, s[15:12],
                      1'b1, s[11:8],  1'b1, s[7:4],   1'b1, s[3:0]};
    endfunction

    assign load     = bit_en && (bit_idx == 8'd0);
    assign s_ready  = !rst && (chan_cnt < 4'd8) && !load;
    assign accept   = s_valid && s_ready;
    assign chan_idx = chan_cnt[2:0];

    // First-transmitted bit sits at the MSB, so frame index i lives at position ~i.
    assign frame_msb = {10'd0, 2'b11, user_q,
                        chan_field(tx_smp[0]), chan_field(tx_smp[1]),
                        chan_field(tx_smp[2]), chan_field(tx_smp[3]),
                        chan_field(tx_smp[4]), chan_field(tx_smp[5]),
                        chan_field(tx_smp[6]), chan_field(tx_smp[7])};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                staging[i] <= '0;
                tx_smp[i]  <= '0;
            end
            chan_cnt       <= '0;
            bit_idx        <= '0;
            user_q         <= '0;
            adat_bitstream <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (bit_en) begin
                adat_bitstream <= adat_bitstream ^ frame_msb[~bit_idx];
                bit_idx        <= bit_idx + 8'd1;
            end

            // Bits 0..10 are constant, so swapping tx_smp on this same edge is safe.
            if (load) begin
                frame_start <= 1'b1;
                user_q      <= user_bits;
                chan_cnt    <= '0;
                if (chan_cnt == 4'd8) begin
                    for (int i = 0; i < 8; i++) tx_smp[i] <= staging[i];
                end else begin
                    underrun <= 1'b1;
                    if (!UNDERRUN_HOLD) begin
                        for (int i = 0; i < 8; i++) tx_smp[i] <= '0;
                    end
                end
            end else if (accept) begin
                staging[chan_cnt[2:0]] <= s_data;
                chan_cnt               <= chan_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/adat_stream_tx.md
ADAT_STREAM_TX -- requirements
Module: adat_stream_tx

Interface
REQ-001 SHALL have parameter UNDERRUN_HOLD, default 0; 0 = transmit all-zero samples on underrun, 1 = retransmit previous frame's samples.
REQ-002 SHALL have port clk  input  1  single clock for all logic (bit rate or oversampled).
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port bit_en  input  1  one-cycle strobe; each high cycle advances one ADAT bit period.
REQ-005 SHALL have port s_data  input  24  signed sample for the next expected channel.
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-008 SHALL have port user_bits  input  4  ADAT user nibble.
REQ-009 SHALL have port adat_bitstream  output  1  NRZI-encoded ADAT line.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse at each frame load.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse when a frame is loaded without 8 staged samples.
REQ-012 SHALL have port chan_idx  output  3  channel number the next accepted sample is assigned to.

Function
REQ-013 SHALL keep 8x24-bit staging buffer, channel counter (0..8) and 8-bit bit index (0..255, wraps 255->0).
REQ-014 Handshake SHALL occur when s_valid && s_ready on a rising clk; s_data written to staging[chan_idx], chan_idx incremented.
REQ-015 s_ready SHALL be high iff channel counter < 8 and NOT (bit_en && bit index == 0); combinational in bit_en only.
REQ-016 chan_idx SHALL equal channel counter[2:0]; value 0 when counter == 8.
REQ-017 Frame load SHALL occur on the clk edge where bit_en == 1 and bit index == 0.
REQ-018 At load with counter == 8: staging copied to transmit registers, user_bits captured, counter cleared to 0.
REQ-019 At load with counter < 8 (including partial 1..7): underrun pulsed; transmit samples = zeros if UNDERRUN_HOLD == 0 else unchanged; user_bits still captured; counter cleared, partial staging discarded.
REQ-020 frame_start SHALL pulse high for exactly the load cycle, every frame, regardless of underrun.
REQ-021 Frame bit layout (index 0..255): 0-9 = '0'; 10 = '1'; 11 = '1'; 12-15 = user bits MSB first; then for ch 0..7, nibble 5..0 (s[23:20] first): '1' followed by 4 nibble bits MSB first.
REQ-022 Channel c nibble n (n=0 for bits 23:20) group SHALL start at index 16 + 30c + 5n; ch7 last bit at index 255.
REQ-023 NRZI: on each bit_en edge, adat_bitstream SHALL toggle if current frame bit is '1', hold if '0'; bit index then increments.
REQ-024 Bit for index 0..10 SHALL not depend on transmit registers (load same edge as index 0 is safe).
REQ-025 Without bit_en, bit index, adat_bitstream and transmit registers SHALL hold; handshakes SHALL still proceed.
REQ-026 After a load, staging SHALL accept next frame immediately (next cycle), giving one full frame of buffering latency: samples accepted in frame N transmitted in frame N+1.
REQ-027 bit_en consecutive-cycle strobes SHALL be supported (bit-rate clock, bit_en tied high).

Reset
REQ-028 While rst high: adat_bitstream 0, bit index 0, channel counter 0, transmit registers and staging 0, captured user bits 0, frame_start 0, underrun 0, s_ready 0.
REQ-029 First cycle after rst low: s_ready 1, chan_idx 0; first bit_en triggers load (underrun pulse unless 8 samples already staged).
REQ-030 rst asserted mid-frame or mid-handshake SHALL abandon frame and staged samples; no partial frame resumes.

Verification
REQ-031 bit_en tied high, 8 samples 0x000000 then reset-released loop with user_bits=0 -> each frame: 10 constant bits, toggles at indices 10,11 and every 5th bit from 16; period 256 cycles.
REQ-032 Stage ch0=0xF00000, others 0, user_bits=0xA before load -> decoded frame N+1 bits 16-20 = 1,1,1,1,1, bits 12-15 = 1,0,1,0; underrun never pulses.
REQ-033 Stage only 5 samples before load, UNDERRUN_HOLD=0 -> underrun and frame_start pulse same cycle; all data nibbles zero; chan_idx returns to 0.
REQ-034 UNDERRUN_HOLD=1, full frame 0x123456.. then empty frame -> second frame repeats same 8 samples; underrun pulses once.
REQ-035 s_valid high exactly at bit_en && index 0 -> s_ready 0 that cycle, sample accepted next cycle as ch0 of next frame.
REQ-036 bit_en every 8th cycle, rst pulsed at bit index 100 -> adat_bitstream 0, index 0, staging empty next cycle; clean frame restarts.
